// File: rtl/aes_dec_pkg.sv
// Shared types, GF(2^8) helpers and reference vectors for the iterative AES decryptor.
package aes_dec_pkg;

    typedef enum logic [2:0] {StIdle, StInit, StRound, StFinal, StDone} decState_e;

    // Rounds for a given key size: 128 -> 10, 192 -> 12, 256 -> 14.
    function automatic int unsigned nr_of(input int unsigned keyBits);
        return keyBits / 32 + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] acc;
        p = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            acc = gmul(acc, p);
        end
        return acc;
    endfunction

    // Inverse affine transform followed by field inversion.
    function automatic logic [7:0] invSbox(input logic [7:0] s);
        logic [7:0] a;
        a = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return ginv(a);
    endfunction

    // FIPS-197 appendix C vectors.
    localparam logic [127:0] FIPS_KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] FIPS_KEY192 =
        192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] FIPS_KEY256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] FIPS_CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    // SP800-38A F.1.1 / F.2.1 AES-128 vectors.
    localparam logic [127:0] SP_KEY      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SP_IV       = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SP_PT1      = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] SP_PT2      = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] SP_ECB_CT1  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] SP_CBC_CT1  = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] SP_CBC_CT2  = 128'h5086cb9b507219ee95db113a917678b2;

endpackage

// File: rtl/aes_dec_round_dp.sv
// Combinational inverse-round datapath. roundMode=0: InvSubBytes(InvShiftRows(st ^ rk)).
// roundMode=1: InvSubBytes(InvShiftRows(InvMixColumns(st ^ rk))).
module aes_dec_round_dp
    import aes_dec_pkg::*;
(
    input  logic         roundMode,
    input  logic [127:0] stIn,
    input  logic [127:0] rk,
    output logic [127:0] stOut
);

    // Byte k of the block sits at [127-8k -: 8]; row = k % 4, column = k / 4.
    function automatic logic [127:0] invShiftRows(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] invMixColumns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127 - 8 * (4 * c + r) -: 8];
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = gmul(a[r], 8'h0e) ^ gmul(a[(r + 1) % 4], 8'h0b)
                                              ^ gmul(a[(r + 2) % 4], 8'h0d)
                                              ^ gmul(a[(r + 3) % 4], 8'h09);
            end
        end
        return o;
    endfunction

    logic [127:0] ark;
    logic [127:0] shifted;

    // Add round key, optional InvMixColumns, then InvShiftRows and bytewise InvSubBytes.
    always_comb begin
        ark     = stIn ^ rk;
        shifted = invShiftRows(roundMode ? invMixColumns(ark) : ark);
        for (int k = 0; k < 16; k++) stOut[8 * k +: 8] = invSbox(shifted[8 * k +: 8]);
    end

endmodule

// File: rtl/aes_dec_iter_core.sv
// Iterative AES-128/192/256 inverse cipher, one round per clock, valid/ready on both sides.
// Define AES_DEC_CBC_EN to add CBC chaining (cbc_en, iv_load, iv ports and a chain register).
module aes_dec_iter_core
    import aes_dec_pkg::*;
#(
    parameter int unsigned KEY_BITS = 128,
    parameter int unsigned RKI_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic [RKI_W-1:0] rk_idx,
    input  logic [127:0]     rk_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data
`ifdef AES_DEC_CBC_EN
    ,
    input  logic             cbc_en,
    input  logic             iv_load,
    input  logic [127:0]     iv
`endif
);

    localparam int unsigned      NR     = nr_of(KEY_BITS);
    localparam logic [RKI_W-1:0] NR_IDX = RKI_W'(NR);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : gBadKeyBits
        $error("aes_dec_iter_core: KEY_BITS must be 128, 192 or 256");
    end

    decState_e        stateQ, stateD;
    logic [127:0]     stQ, stD;
    logic [RKI_W-1:0] rQ, rD;
    logic [127:0]     outDataQ, outDataD;
    logic             outValidQ, outValidD;
    logic [127:0]     dpOut;
    logic             dpRound;
    logic [127:0]     chainMask;
    logic             accept;

    aes_dec_round_dp uDp (
        .roundMode (dpRound),
        .stIn      (stQ),
        .rk        (rk_data),
        .stOut     (dpOut)
    );

    assign accept = in_valid & in_ready;

    // FSM next state, round-key index and handshake outputs.
    always_comb begin
        stateD    = stateQ;
        stD       = stQ;
        rD        = rQ;
        outDataD  = outDataQ;
        outValidD = outValidQ;
        rk_idx    = NR_IDX;
        in_ready  = 1'b0;
        dpRound   = 1'b0;
        case (stateQ)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    stD    = in_data;
                    stateD = StInit;
                end
            end
            StInit: begin
                rk_idx = NR_IDX;
                stD    = dpOut;
                rD     = NR_IDX - 1'b1;
                stateD = StRound;
            end
            StRound: begin
                rk_idx  = rQ;
                dpRound = 1'b1;
                stD     = dpOut;
                if (rQ == RKI_W'(1)) stateD = StFinal;
                else rD = rQ - 1'b1;
            end
            StFinal: begin
                rk_idx    = '0;
                outDataD  = stQ ^ rk_data ^ chainMask;
                outValidD = 1'b1;
                stateD    = StDone;
            end
            StDone: begin
                // Output handoff and next input may happen on the same edge.
                in_ready = out_ready;
                if (out_ready) begin
                    outValidD = 1'b0;
                    if (in_valid) begin
                        stD    = in_data;
                        stateD = StInit;
                    end else begin
                        stateD = StIdle;
                    end
                end
            end
            default: stateD = StIdle;
        endcase
    end

    // State, round counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= StIdle;
            stQ       <= '0;
            rQ        <= '0;
            outDataQ  <= '0;
            outValidQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            stQ       <= stD;
            rQ        <= rD;
            outDataQ  <= outDataD;
            outValidQ <= outValidD;
        end
    end

`ifdef AES_DEC_CBC_EN
    logic [127:0] chainQ, chainD;
    logic [127:0] ctQ, ctD;
    logic         cbcQ, cbcD;

    // IV load only while idle; chain advances to this block's ciphertext once it is emitted.
    always_comb begin
        chainD = chainQ;
        ctD    = ctQ;
        cbcD   = cbcQ;
        if (stateQ == StIdle && iv_load) chainD = iv;
        if (accept) begin
            ctD  = in_data;
            cbcD = cbc_en;
        end
        if (stateQ == StFinal && cbcQ) chainD = ctQ;
    end

    // CBC chain, captured ciphertext and sampled mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chainQ <= '0;
            ctQ    <= '0;
            cbcQ   <= 1'b0;
        end else begin
            chainQ <= chainD;
            ctQ    <= ctD;
            cbcQ   <= cbcD;
        end
    end

    assign chainMask = cbcQ ? chainQ : '0;
`else
    assign chainMask = '0;
`endif

    assign out_valid = outValidQ;
    assign out_data  = outDataQ;

endmodule

// File: tb/tb_aes_dec_iter_core.sv
// Directed bench: three cores (128/192/256-bit keys) fed by a bench-side expanded-key store.
module tb_aes_dec_iter_core;
    import aes_dec_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         inValid [3];
    logic         inReady [3];
    logic [127:0] inData  [3];
    logic [3:0]   rkIdx   [3];
    logic [127:0] rkData  [3];
    logic         outValid[3];
    logic         outReady[3];
    logic [127:0] outData [3];
    logic [127:0] rks     [3][16];
`ifdef AES_DEC_CBC_EN
    logic         cbcEn;
    logic         ivLoad;
    logic [127:0] iv;
`endif

    for (genvar g = 0; g < 3; g++) begin : gDut
        assign rkData[g] = rks[g][rkIdx[g]];
        aes_dec_iter_core #(
            .KEY_BITS (128 + 64 * g),
            .RKI_W    (4)
        ) uDut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (inValid[g]),
            .in_ready  (inReady[g]),
            .in_data   (inData[g]),
            .rk_idx    (rkIdx[g]),
            .rk_data   (rkData[g]),
            .out_valid (outValid[g]),
            .out_ready (outReady[g]),
            .out_data  (outData[g])
`ifdef AES_DEC_CBC_EN
            ,
            .cbc_en    (cbcEn),
            .iv_load   (ivLoad),
            .iv        (iv)
`endif
        );
    end

    typedef struct {
        int           inst;
        int           keyBits;
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        int           lat;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] sbox [256];
    int         checks;
    int         errors;

    // Plain polynomial product reduced by 0x11b.
    function automatic logic [7:0] tbMul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // FIPS-197 key expansion into the store of one instance (key left-aligned in 256 bits).
    task automatic expandKey(input int inst, input int keyBits, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int          nk;
        int          nr;
        nk   = keyBits / 32;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rks[inst][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Present one block in IDLE and let it be taken on the next edge.
    task automatic acceptBlock(input int inst, input logic [127:0] ct);
        inData[inst]  = ct;
        inValid[inst] = 1'b1;
        #1;
        check("accept_in_ready", inReady[inst], 1'b1);
        @(posedge clk);
        #1;
        inValid[inst] = 1'b0;
    endtask

    task automatic waitOut(input int inst, output logic [127:0] data, output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (outValid[inst]) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout: got 0 expected 1 within 40 cycles (inst %0d)", inst);
        end
        data = outData[inst];
    endtask

    task automatic takeOut(input int inst);
        outReady[inst] = 1'b1;
        @(posedge clk);
        #1;
        outReady[inst] = 1'b0;
    endtask

    logic [127:0] got;
    int           lat;
    int           expIdx;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int g = 0; g < 3; g++) begin
            inValid[g]  = 1'b0;
            outReady[g] = 1'b0;
            inData[g]   = '0;
        end
`ifdef AES_DEC_CBC_EN
        cbcEn  = 1'b0;
        ivLoad = 1'b0;
        iv     = '0;
`endif
        // Forward S-box by brute-force inversion plus affine map.
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (tbMul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        expandKey(1, 192, {FIPS_KEY192, 64'h0});
        expandKey(2, 256, FIPS_KEY256);

        vecs[0] = '{0, 128, {FIPS_KEY128, 128'h0}, FIPS_CT128, FIPS_PT, 11};
        vecs[1] = '{1, 192, {FIPS_KEY192, 64'h0}, FIPS_CT192, FIPS_PT, 13};
        vecs[2] = '{2, 256, FIPS_KEY256, FIPS_CT256, FIPS_PT, 15};
        vecs[3] = '{0, 128, {SP_KEY, 128'h0}, SP_ECB_CT1, SP_PT1, 11};
        // Raw (ECB) decryption of the CBC blocks: pt ^ previous ciphertext.
        vecs[4] = '{0, 128, {SP_KEY, 128'h0}, SP_CBC_CT1,
                    128'h6bc0bce12a459991e134741a7f9e1925, 11};
        vecs[5] = '{0, 128, {SP_KEY, 128'h0}, SP_CBC_CT2,
                    128'hd86421fb9f1a1eda505ee1375746972c, 11};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        for (int g = 0; g < 3; g++) begin
            check("reset_out_valid", outValid[g], 1'b0);
            check("reset_out_data", outData[g], 128'h0);
            check("reset_in_ready", inReady[g], 1'b1);
            check("reset_rk_idx", rkIdx[g], 10 + 2 * g);
        end

        // Table: known-answer vectors with latency.
        for (int v = 0; v < 6; v++) begin
            expandKey(vecs[v].inst, vecs[v].keyBits, vecs[v].key);
            acceptBlock(vecs[v].inst, vecs[v].ct);
            waitOut(vecs[v].inst, got, lat);
            check($sformatf("vec%0d_plaintext", v), got, vecs[v].pt);
            check($sformatf("vec%0d_latency", v), lat, vecs[v].lat);
            takeOut(vecs[v].inst);
            check($sformatf("vec%0d_taken", v), outValid[vecs[v].inst], 1'b0);
        end

        // Backpressure, then back-to-back handoff in DONE.
        expandKey(0, 128, {SP_KEY, 128'h0});
        acceptBlock(0, SP_ECB_CT1);
        waitOut(0, got, lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_data", outData[0], SP_PT1);
            check("bp_out_valid", outValid[0], 1'b1);
            check("bp_in_ready", inReady[0], 1'b0);
            @(posedge clk);
            #1;
        end
        inData[0]   = SP_CBC_CT1;
        inValid[0]  = 1'b1;
        outReady[0] = 1'b1;
        #1;
        check("handoff_in_ready", inReady[0], 1'b1);
        @(posedge clk);
        #1;
        inValid[0]  = 1'b0;
        outReady[0] = 1'b0;
        check("handoff_out_taken", outValid[0], 1'b0);
        check("handoff_busy", inReady[0], 1'b0);
        waitOut(0, got, lat);
        check("handoff_plaintext", got, 128'h6bc0bce12a459991e134741a7f9e1925);
        check("handoff_latency", lat, 11);
        takeOut(0);

        // Reset in ROUND at r=5, and reset while holding a result in DONE.
        expandKey(0, 128, {FIPS_KEY128, 128'h0});
        acceptBlock(0, FIPS_CT128);
        repeat (5) @(posedge clk);
        #1;
        check("mid_round_rk_idx", rkIdx[0], 4'd5);
        rst_n = 1'b0;
        #1;
        check("rst_round_out_valid", outValid[0], 1'b0);
        check("rst_round_in_ready", inReady[0], 1'b1);
        check("rst_round_rk_idx", rkIdx[0], 4'd10);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        acceptBlock(0, FIPS_CT128);
        waitOut(0, got, lat);
        check("after_rst_plaintext", got, FIPS_PT);
        rst_n = 1'b0;
        #1;
        check("rst_done_out_valid", outValid[0], 1'b0);
        check("rst_done_out_data", outData[0], 128'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        acceptBlock(0, FIPS_CT128);
        waitOut(0, got, lat);
        check("after_rst2_plaintext", got, FIPS_PT);
        takeOut(0);

        // in_valid held with junk data while busy; rk_idx walked cycle by cycle.
        inData[0]  = FIPS_CT128;
        inValid[0] = 1'b1;
        @(posedge clk);
        #1;
        inData[0] = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        for (int j = 0; j <= 11; j++) begin
            expIdx = (j == 0) ? 10 : (j < 10) ? 10 - j : (j == 10) ? 0 : 10;
            check($sformatf("rk_idx_step%0d", j), rkIdx[0], expIdx);
            if (j <= 10) check($sformatf("busy_in_ready_step%0d", j), inReady[0], 1'b0);
            if (j < 11) begin
                @(posedge clk);
                #1;
            end
        end
        check("held_valid_out_valid", outValid[0], 1'b1);
        check("held_valid_plaintext", outData[0], FIPS_PT);
        inValid[0] = 1'b0;
        takeOut(0);

`ifdef AES_DEC_CBC_EN
        // CBC: IV loaded with the first block; later IV strobes while busy are ignored.
        expandKey(0, 128, {SP_KEY, 128'h0});
        cbcEn  = 1'b1;
        ivLoad = 1'b1;
        iv     = SP_IV;
        acceptBlock(0, SP_CBC_CT1);
        iv = 128'hffeeddccbbaa99887766554433221100;
        waitOut(0, got, lat);
        check("cbc_block1", got, SP_PT1);
        check("cbc_block1_latency", lat, 11);
        ivLoad = 1'b0;
        takeOut(0);
        acceptBlock(0, SP_CBC_CT2);
        cbcEn = 1'b0;
        waitOut(0, got, lat);
        check("cbc_block2", got, SP_PT2);
        takeOut(0);
        acceptBlock(0, SP_CBC_CT1);
        waitOut(0, got, lat);
        check("cbc_off_block", got, 128'h6bc0bce12a459991e134741a7f9e1925);
        takeOut(0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
